// File: rtl/ram_arb_pkg.sv
// Shared types and default RAM geometry for the arbiter, DMA and coordinator.
// The arbiter's state encoding lives here so the coordinator can observe it.
package ram_arb_pkg;

  localparam int RAM_AW = 16;
  localparam int RAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arbState_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first asserted req at or above rrPtr, wrapping at N.
// Zero latency; no flow control of its own.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rrPtr,
  output logic [N-1:0]  winOneHot,
  output logic [PW-1:0] winIdx,
  output logic          anyReq
);

  logic [PW:0]   candSum;
  logic [PW-1:0] candIdx;

  always_comb begin
    winOneHot = '0;
    winIdx    = '0;
    anyReq    = 1'b0;
    candSum   = '0;
    candIdx   = '0;
    for (int k = 0; k < N; k++) begin
      // rrPtr + k never exceeds 2N-2, so a single conditional subtract wraps it.
      candSum = {1'b0, rrPtr} + (PW+1)'(k);
      if (candSum >= (PW+1)'(N)) candSum = candSum - (PW+1)'(N);
      candIdx = candSum[PW-1:0];
      if (!anyReq && req[candIdx]) begin
        anyReq             = 1'b1;
        winIdx             = candIdx;
        winOneHot[candIdx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin owner of the single DMA/RAM port; one outstanding access, grant held until DMA done or timeout abort.
// req->gnt/strobe 1 cycle, DMA done->done pulse 1 cycle; requesters stall holding req until their done pulse.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int AW      = RAM_AW,
  parameter int DW      = RAM_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  req_we,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]  gnt,
  output logic [N-1:0]  done,
  output logic [DW-1:0] rdata,
  output logic          timeout_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done_read,
  input  logic          mem_done_write
);

  localparam int PW = $clog2(N);

  arbState_t     state, stateNext;
  logic [PW-1:0] rrPtr, winIdx, grantIdx;
  logic [N-1:0]  winOneHot;
  logic          anyReq, isWrite, doneHit, timeoutHit;
  logic [15:0]   waitCnt;

  rr_picker #(.N(N), .PW(PW)) picker (
    .req       (req),
    .rrPtr     (rrPtr),
    .winOneHot (winOneHot),
    .winIdx    (winIdx),
    .anyReq    (anyReq)
  );

  // Only the completion matching the issued direction counts.
  assign doneHit    = isWrite ? mem_done_write : mem_done_read;
  assign timeoutHit = ({1'b0, waitCnt} + 17'd1) == 17'(TIMEOUT);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (anyReq) stateNext = ISSUE;
      ISSUE:   stateNext = WAIT;
      WAIT:    if (doneHit || timeoutHit) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= IDLE;
      rrPtr       <= '0;
      grantIdx    <= '0;
      waitCnt     <= '0;
      isWrite     <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      timeout_err <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      state <= stateNext;
      done  <= '0;
      case (state)
        // Winner is captured on the IDLE->ISSUE edge so gnt/strobe appear one cycle after req.
        IDLE: if (anyReq) begin
          grantIdx  <= winIdx;
          gnt       <= winOneHot;
          isWrite   <= req_we[winIdx];
          mem_read  <= ~req_we[winIdx];
          mem_write <= req_we[winIdx];
          mem_addr  <= req_addr[winIdx*AW +: AW];
          mem_wdata <= req_wdata[winIdx*DW +: DW];
          waitCnt   <= '0;
        end
        WAIT: begin
          waitCnt <= waitCnt + 16'd1;
          if (doneHit || timeoutHit) begin
            done      <= gnt;
            gnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rrPtr     <= (grantIdx == PW'(N-1)) ? '0 : grantIdx + PW'(1);
            if (doneHit) begin
              if (!isWrite) rdata <= mem_rdata;
            end else begin
              rdata       <= '0;
              timeout_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single DMA/RAM port between up to N requesters (decompress handler, file handler, CNN engine, external host), replacing the static load/cnn mux selection in the top-level coordinator.
- Round-robin arbitration with one outstanding transaction; grant held until the DMA reports done-read/done-write or a timeout fires.
- Sits between the requester modules and the DMA module.

Parameters:
- N, 4, number of requesters (2..8)
- AW, 16, RAM address width
- DW, 8, RAM data width
- TIMEOUT, 255, max cycles waiting for DMA done before abort (1..65535)

Ports:
- clk  in  1  system clock, rising edge
- RST  in  1  reset, synchronous, active-high
- req  in  N  per-requester access request (level)
- req_we  in  N  per-requester 1=write, 0=read
- req_addr  in  N*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  N*DW  packed write data, requester i at [i*DW +: DW]
- gnt  out  N  one-hot grant, held for the whole transaction
- done  out  N  one-cycle completion pulse to the granted requester
- rdata  out  DW  registered read data, valid while done is high
- timeout_err  out  1  sticky; set on any abort, cleared only by RST
- mem_addr  out  AW  address to DMA
- mem_wdata  out  DW  write data to DMA
- mem_read  out  1  read strobe to DMA (level)
- mem_write  out  1  write strobe to DMA (level)
- mem_rdata  in  DW  read data from DMA
- mem_done_read  in  1  DMA read complete
- mem_done_write  in  1  DMA write complete

Behaviour:
- Reset (synchronous): state=IDLE, rr_ptr=0, timeout counter=0; all outputs 0 (gnt, done, rdata, timeout_err, mem_*).
- FSM states:
  - IDLE: pick the first asserted req scanning from rr_ptr upward with wrap at N. No req -> stay.
  - ISSUE: latch addr/wdata/we of the winner into mem_* registers; assert gnt and mem_read or mem_write. Lasts one cycle -> WAIT.
  - WAIT: strobes held; counter increments each cycle.
    - Matching done (mem_done_read for a read, mem_done_write for a write) -> RESP; capture mem_rdata on reads.
    - Counter reaches TIMEOUT -> RESP with abort.
  - RESP: done[i]=1 for one cycle; strobes and gnt drop; rr_ptr=(i+1) mod N; -> IDLE.
    - Abort additionally sets timeout_err; rdata is 0 on abort.
- Timing:
  - req seen in cycle t -> gnt and strobe in t+1.
  - DMA done in cycle u -> done pulse in u+1.
  - Minimum 4 cycles per access (IDLE, ISSUE, WAIT, RESP), so back-to-back accesses from one requester are separated by an IDLE cycle.
- Mismatched done (e.g. done_write during a read) is ignored.
- Done and timeout in the same cycle: done wins, no error.
- Requesters must hold req/addr/wdata until their done pulse.
  - Deasserting req mid-transaction does not abort; done is still pulsed.
  - Request inputs are sampled only in IDLE; changes after ISSUE have no effect.
- gnt is never multi-hot; mem_read and mem_write are never both high.
- Requests with index >= N are impossible by construction; rr_ptr width is clog2(N) and wraps explicitly.
- RST mid-transaction: immediate return to IDLE with all outputs 0 next edge; the in-flight requester receives no done.

Decomposition:
- Shared package ram_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - default AW/DW constants, shared with the DMA and coordinator
- One sub-module, rr_picker: combinational round-robin selector (req, rr_ptr -> one-hot winner and index). Everything else lives in ram_port_arbiter.

Test Plan:
- Single read: req[1]=1, req_we=0, addr1=16'h0040; DMA returns 8'hA5 with done_read 3 cycles after mem_read -> gnt=4'b0010 next cycle, mem_addr=16'h0040, done[1] pulses once, rdata=8'hA5, error flag clear.
- Round-robin fairness: req=4'b1111 held; each access completes in 2 cycles -> grant order 0,1,2,3,0,...; no requester granted twice while another waits.
- Write path: req[2]=1, we=1, addr=16'h0100, wdata=8'h3C -> mem_write=1, mem_wdata=8'h3C, mem_read=0; done_write -> done[2] pulse; a spurious done_read beforehand is ignored.
- Timeout: TIMEOUT=8, DMA never answers -> strobe drops after 8 WAIT cycles, done[0] pulses, rdata=0, timeout_err=1 and stays 1; a later normal access still completes.
- Done/timeout collision: done_read arrives on the exact cycle the counter reaches TIMEOUT -> normal completion, timeout_err stays 0.
- Reset mid-access: assert RST during WAIT -> next edge all outputs 0, state IDLE, rr_ptr=0; no done pulse for the aborted requester.
